// File: rtl/traffic_pkg.sv
// Shared lamp and state encodings for the highway/country signal controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } lamp_t;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Dwell counter for the current phase: clears on restart, otherwise counts up
// and saturates; done flags that the phase has reached its final cycle.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             restart,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] tmr,
  output logic             done
);

  logic [CNT_W-1:0] r_tmr;
  logic [CNT_W:0]   w_tmrPlusOne;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_tmr <= '0;
    end else if (restart) begin
      r_tmr <= '0;
    end else if (r_tmr != {CNT_W{1'b1}}) begin
      r_tmr <= r_tmr + CNT_W'(1);
    end
  end

  // tmr >= limit-1, evaluated one bit wider so limit=0 cannot underflow
  assign w_tmrPlusOne = {1'b0, r_tmr} + (CNT_W + 1)'(1);
  assign done         = (w_tmrPlusOne >= {1'b0, limit});
  assign tmr          = r_tmr;

endmodule

// File: rtl/traffic_sig_control_param.sv
// Highway/country intersection sequencer with parametrised phase durations.
// Optional pedestrian walk phase enabled by defining PED_WALK_EN.
module traffic_sig_control_param
  import traffic_pkg::*;
#(
  parameter int Y2R_DELAY      = 3,
  parameter int R2G_DELAY      = 2,
  parameter int HWY_MIN_GREEN  = 8,
  parameter int CTRY_MAX_GREEN = 16,
  parameter int WALK_TIME      = 6,
  parameter int CNT_W          = 8
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       x,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output lamp_t      highway,
  output lamp_t      country,
  output logic [2:0] state
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_tmr;
  logic             w_done;
  logic             w_restart;
  logic             w_request;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef PED_WALK_EN
  logic r_pedPending;

  // A fresh request wins over the clear so a press on the S2->S6 edge is kept
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_pedPending <= 1'b0;
    end else if (ped_req) begin
      r_pedPending <= 1'b1;
    end else if (r_state == S2 && w_next == S6) begin
      r_pedPending <= 1'b0;
    end
  end

  assign w_request = x | r_pedPending;
  assign walk      = (r_state == S6);
`else
  assign w_request = x;
`endif

  always_comb begin
    w_limit = CNT_W'(HWY_MIN_GREEN);
    case (r_state)
      S1, S4:  w_limit = CNT_W'(Y2R_DELAY);
      S2, S5:  w_limit = CNT_W'(R2G_DELAY);
      S3:      w_limit = CNT_W'(CTRY_MAX_GREEN);
      S6:      w_limit = CNT_W'(WALK_TIME);
      default: w_limit = CNT_W'(HWY_MIN_GREEN);
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S0: if (w_request && (w_tmr >= CNT_W'(HWY_MIN_GREEN - 1))) w_next = S1;
      S1: if (w_done) w_next = S2;
`ifdef PED_WALK_EN
      S2: if (w_done) w_next = r_pedPending ? S6 : S3;
`else
      S2: if (w_done) w_next = S3;
`endif
      S3: if (!x || w_done) w_next = S4;
      S4: if (w_done) w_next = S5;
      S5: if (w_done) w_next = S0;
`ifdef PED_WALK_EN
      S6: if (w_done) w_next = x ? S3 : S5;
`endif
      default: w_next = S0;
    endcase
  end

  assign w_restart = (w_next != r_state);

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock  (clock),
    .clear_n(clear_n),
    .restart(w_restart),
    .limit  (w_limit),
    .tmr    (w_tmr),
    .done   (w_done)
  );

  // Unknown encodings show red both ways until the FSM recovers to S0
  always_comb begin
    highway = RED;
    country = RED;
    case (r_state)
      S0:      highway = GREEN;
      S1:      highway = YELLOW;
      S3:      country = GREEN;
      S4:      country = YELLOW;
      default: begin
        highway = RED;
        country = RED;
      end
    endcase
  end

  assign state = r_state;

endmodule
